// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN parameter loader.
// Neuron geometry sets the default serial chain length.
package bnn_pkg;

  localparam int BNN_INPUTS      = 8;
  localparam int BNN_BIAS_BITS   = 3;
  localparam int BNN_NEURON_BITS = BNN_INPUTS + BNN_BIAS_BITS;
  localparam int BNN_NEURONS     = 8;
  localparam int BNN_CHAIN_BITS  = BNN_NEURONS * BNN_NEURON_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  // Left-align an n-bit partial byte, zero-padding its LSBs.
  function automatic logic [7:0] rb_pad(
    input logic [7:0] b,
    input logic [3:0] n
  );
    return b << (4'd8 - n);
  endfunction

endpackage

// File: rtl/bnn_param_fifo.sv
// Byte FIFO with valid/ready on both sides, power-of-two depth.
// Simultaneous push and pop are both honoured.
module bnn_param_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign in_ready  = (r_cnt != FULL) && !reset;
  assign out_valid = (r_cnt != '0);
  assign out_data  = r_mem[r_rp];
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/bnn_param_loader.sv
// Streams buffered parameter bytes MSB-first into a BNN neuron chain.
// Define BNN_PARAM_READBACK_EN to reassemble the displaced chain bits.
module bnn_param_loader
  import bnn_pkg::*;
#(
  parameter int CHAIN_BITS = BNN_CHAIN_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       setup,
  output logic       param_in,
  input  logic       param_tail,
  output logic [7:0] rb_data,
  output logic       rb_valid
);

  localparam int CW = $clog2(CHAIN_BITS + 1);
  localparam logic [CW-1:0] LAST    = CHAIN_BITS[CW-1:0];
  localparam logic [CW-1:0] LAST_M1 = LAST - 1'b1;

  ld_state_e     r_state;
  ld_state_e     w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_sr;
  logic [3:0]    r_sr_n;
  logic          r_setup;
  logic          r_param_in;

  logic [7:0] w_fifo_data;
  logic       w_fifo_valid;
  logic       w_load;
  logic       w_more;
  logic       w_shift;
  logic       w_last;
  logic       w_refill;
  logic       w_fill;

  bnn_param_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (w_fifo_data),
    .out_valid (w_fifo_valid),
    .out_ready (w_refill)
  );

  assign w_load  = (r_state == ST_LOAD);
  assign w_more  = (r_cnt != LAST);
  assign w_shift = w_load && w_more && (r_sr_n != 4'd0);
  assign w_last  = w_shift && (r_cnt == LAST_M1);

  // Refill on empty or on the final shift of a byte, but never past the last bit.
  assign w_refill = w_load && w_more && !w_last &&
                    ((r_sr_n == 4'd0) || (r_sr_n == 4'd1));
  assign w_fill   = w_refill && w_fifo_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start)   w_next = ST_LOAD;
      ST_LOAD: if (!w_more) w_next = ST_DONE;
      ST_DONE:              w_next = ST_IDLE;
      default:              w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_DONE);
    setup    = r_setup;
    param_in = r_param_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_sr       <= '0;
      r_sr_n     <= '0;
      r_setup    <= 1'b0;
      r_param_in <= 1'b0;
    end else begin
      r_setup <= w_shift;
      if (w_shift) r_param_in <= r_sr[7];

      if ((r_state == ST_IDLE) && start) r_cnt <= '0;
      else if (w_shift)                  r_cnt <= r_cnt + 1'b1;

      // Leftover bits of a partial final byte are dropped here.
      if (w_load && !w_more) begin
        r_sr   <= '0;
        r_sr_n <= '0;
      end else if (w_fill) begin
        r_sr   <= w_fifo_data;
        r_sr_n <= 4'd8;
      end else if (w_shift) begin
        r_sr   <= {r_sr[6:0], 1'b0};
        r_sr_n <= r_sr_n - 1'b1;
      end
    end
  end

`ifdef BNN_PARAM_READBACK_EN
  logic [6:0] r_rb_sr;
  logic [2:0] r_rb_n;
  logic [7:0] r_rb_data;
  logic       r_rb_valid;
  logic [7:0] w_rb_byte;
  logic       w_rb_full;
  logic       w_rb_fin;

  assign w_rb_byte = {r_rb_sr, param_tail};
  assign w_rb_full = (r_rb_n == 3'd7);
  assign w_rb_fin  = r_setup && w_load && !w_more;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rb_sr    <= '0;
      r_rb_n     <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if ((r_state == ST_IDLE) && start) begin
        r_rb_n <= '0;
      end else if (r_setup) begin
        r_rb_sr <= w_rb_byte[6:0];
        r_rb_n  <= r_rb_n + 1'b1;
        if (w_rb_full || w_rb_fin) begin
          r_rb_valid <= 1'b1;
          r_rb_data  <= rb_pad(w_rb_byte, {1'b0, r_rb_n} + 4'd1);
          r_rb_n     <= '0;
        end
      end
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;
`else
  logic w_unused_tail;

  assign w_unused_tail = param_tail;
  assign rb_data       = 8'h00;
  assign rb_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
// Scoreboard bench for bnn_param_loader with a behavioural neuron chain.
// Readback expectations follow BNN_PARAM_READBACK_EN.
module tb_bnn_param_loader;

  localparam int CB = 88;
  localparam int NB = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       start;
  logic       busy;
  logic       done;
  logic       setup;
  logic       param_in;
  logic       param_tail;
  logic [7:0] rb_data;
  logic       rb_valid;

  logic [7:0] s_in_data;
  logic       s_in_valid;
  logic       s_in_ready;
  logic       s_start;
  logic       s_busy;
  logic       s_done;
  logic       s_setup;
  logic       s_param_in;
  logic [7:0] s_rb_data;
  logic       s_rb_valid;

  always #5 clk = ~clk;

  bnn_param_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .setup      (setup),
    .param_in   (param_in),
    .param_tail (param_tail),
    .rb_data    (rb_data),
    .rb_valid   (rb_valid)
  );

  bnn_param_loader #(
    .CHAIN_BITS (12),
    .FIFO_DEPTH (4)
  ) dut12 (
    .clk        (clk),
    .reset      (reset),
    .in_data    (s_in_data),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .start      (s_start),
    .busy       (s_busy),
    .done       (s_done),
    .setup      (s_setup),
    .param_in   (s_param_in),
    .param_tail (1'b0),
    .rb_data    (s_rb_data),
    .rb_valid   (s_rb_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural neuron chain: shifts on setup, never reset.
  logic [CB-1:0] chain = '0;
  always @(posedge clk) if (setup) chain <= {chain[CB-2:0], param_in};
  assign param_tail = chain[CB-1];

  bit         bitq[$];
  bit         s_bitq[$];
  logic [7:0] rbq[$];
  logic [7:0] cur[$];
  logic [7:0] prev[$];
  bit         rb_chk = 1'b1;
  int nbits, done_cnt, rb_cnt, cyc, first_set, last_set;
  int s_nbits, s_done_cnt;

  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (setup) begin
        nbits++;
        if (first_set < 0) first_set = cyc;
        last_set = cyc;
        if (bitq.size() == 0) check("bitq_underflow", 0, 1);
        else check("param_in", param_in, bitq.pop_front());
      end
      if (done) done_cnt++;
      if (rb_valid) begin
        rb_cnt++;
        if (rb_chk) begin
          if (rbq.size() == 0) check("rbq_underflow", 0, 1);
          else check("rb_data", rb_data, rbq.pop_front());
        end
      end
      if (s_setup) begin
        s_nbits++;
        if (s_bitq.size() == 0) check("s_bitq_underflow", 0, 1);
        else check("s_param_in", s_param_in, s_bitq.pop_front());
      end
      if (s_done) s_done_cnt++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 500) begin
      tick(1);
      guard++;
    end
    if (!in_ready) begin
      check("push_timeout", in_ready, 1);
    end else begin
      @(posedge clk);
      #1;
      for (int i = 7; i >= 0; i--) bitq.push_back(b[i]);
      cur.push_back(b);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic begin_load();
    nbits     = 0;
    done_cnt  = 0;
    rb_cnt    = 0;
    first_set = -1;
    if (rb_chk) foreach (prev[i]) rbq.push_back(prev[i]);
  endtask

  task automatic end_load(string tag);
    int g = 0;
    while (done_cnt == 0 && g < 3000) begin
      tick(1);
      g++;
    end
    check({tag, "_done_seen"}, done_cnt != 0, 1);
    tick(3);
    check({tag, "_nbits"}, nbits, CB);
    check({tag, "_bitq_left"}, bitq.size(), 0);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle"}, {busy, setup}, 0);
`ifdef BNN_PARAM_READBACK_EN
    check({tag, "_rb_pulses"}, rb_cnt, NB);
    if (rb_chk) check({tag, "_rbq_left"}, rbq.size(), 0);
`else
    check({tag, "_rb_off"}, {rb_cnt[23:0], rb_data}, 0);
`endif
    prev = cur;
    cur.delete();
  endtask

  task automatic run_load(input logic [7:0] b, string tag);
    begin_load();
    fork
      repeat (NB) push(b);
      begin
        tick(6);
        pulse_start();
      end
    join
    end_load(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    reset      = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    start      = 1'b0;
    s_in_data  = '0;
    s_in_valid = 1'b0;
    s_start    = 1'b0;
    for (int i = 0; i < NB; i++) prev.push_back(8'h00);
    tick(3);
    check("rst_outs", {in_ready, busy, setup, param_in, done, rb_valid}, 0);
    check("rst_rb_data", rb_data, 0);
    reset = 1'b0;
    tick(1);
    check("rel_ready", {in_ready, busy}, 2'b10);

    run_load(8'hA5, "a5");
    check("a5_consecutive", last_set - first_set + 1, CB);

    run_load(8'h3C, "3c_a");
    run_load(8'h3C, "3c_b");

    begin_load();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i * 19));
    tick(1);
    check("full_ready", in_ready, 0);
    fork
      for (int i = 4; i < NB; i++) push(8'h10 + 8'(i * 19));
      begin
        tick(5);
        check("full_hold", in_ready, 0);
        pulse_start();
      end
    join
    end_load("full");

    begin_load();
    pulse_start();
    tick(5);
    check("empty_stall", {busy, setup}, 2'b10);
    for (int i = 0; i < NB; i++) begin
      push(8'h81 ^ 8'(i * 37));
      tick(12);
      check("gap_setup", setup, 0);
      n0 = nbits;
      tick(5);
      check("gap_hold", nbits, n0);
    end
    end_load("gap");
    check("gap_spread", (last_set - first_set + 1) > CB, 1);

    rb_chk = 1'b0;
    rbq.delete();
    begin_load();
    fork
      repeat (6) push(8'h5A);
      begin
        int g = 0;
        tick(3);
        pulse_start();
        while (nbits < 40 && g < 1000) begin
          tick(1);
          g++;
        end
        check("mid_at40", nbits, 40);
        check("mid_setup_on", setup, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_outs", {setup, busy, in_ready, done}, 0);
        bitq.delete();
        cur.delete();
      end
    join
    tick(2);
    reset = 1'b0;
    tick(1);
    check("mid_rel_ready", in_ready, 1);
    begin_load();
    for (int i = 0; i < 3; i++) push(8'hC3);
    tick(1);
    check("mid_empty3", in_ready, 1);
    push(8'hC3);
    tick(1);
    check("mid_empty4", in_ready, 0);
    fork
      repeat (NB - 4) push(8'hC3);
      begin
        tick(2);
        pulse_start();
      end
    join
    end_load("reload");

    s_nbits    = 0;
    s_done_cnt = 0;
    for (int i = 0; i < 8; i++) s_bitq.push_back(1'b1);
    for (int i = 0; i < 4; i++) s_bitq.push_back(1'b0);
    check("s_ready0", s_in_ready, 1);
    s_in_data  = 8'hFF;
    s_in_valid = 1'b1;
    tick(1);
    check("s_ready1", s_in_ready, 1);
    s_in_data = 8'h0F;
    tick(1);
    s_in_valid = 1'b0;
    s_start    = 1'b1;
    tick(1);
    s_start = 1'b0;
    begin
      int g = 0;
      while (s_done_cnt == 0 && g < 200) begin
        tick(1);
        g++;
      end
    end
    tick(3);
    check("s_nbits", s_nbits, 12);
    check("s_bitq_left", s_bitq.size(), 0);
    check("s_done_once", s_done_cnt, 1);
    check("s_idle", {s_busy, s_setup}, 0);
    s_in_valid = 1'b1;
    s_in_data  = 8'h77;
    tick(3);
    check("s_empty3", s_in_ready, 1);
    tick(1);
    check("s_empty4", s_in_ready, 0);
    s_in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
